// File: rtl/mem_stream_loader.sv
// Fills a DEPTH x WIDTH table from a valid/ready word stream and streams it back in address order.
// The FSM (IDLE/LOAD/DUMP) is exposed on state_dbg for external checkers.
module mem_stream_loader #(
    parameter int WIDTH  = 3,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              dump,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W-1:0] out_addr,
    input  logic              out_ready,
    output logic              busy,
    output logic              load_done,
    output logic              dump_done,
    output logic [ADDR_W:0]   count,
    output logic [1:0]        state_dbg
);

    // Handshakes: a word moves on a rising edge where valid & ready are both high.
    // in_ready depends only on state; out_valid never waits on out_ready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [ADDR_W-1:0]  addr_d;
    logic [ADDR_W:0]    count_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic [ADDR_W-1:0]  out_addr_q;
    logic               load_done_q;
    logic               dump_done_q;

    assign addr_d = addr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            load_done_q <= 1'b0;
            dump_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            load_done_q <= 1'b0;
            dump_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= LOAD;
                        addr_q  <= '0;
                        count_q <= '0;
                    end else if (dump) begin
                        // Word 0 is presented in the first DUMP cycle.
                        state_q     <= DUMP;
                        addr_q      <= '0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= mem_q[0];
                        out_addr_q  <= '0;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        mem_q[addr_q] <= in_data;
                        addr_q        <= addr_d;
                        count_q       <= count_q + 1'b1;
                        if (addr_q == LAST_ADDR) begin
                            state_q     <= IDLE;
                            load_done_q <= 1'b1;
                        end
                    end
                end
                DUMP: begin
                    if (out_valid_q && out_ready) begin
                        if (addr_q == LAST_ADDR) begin
                            state_q     <= IDLE;
                            addr_q      <= '0;
                            out_valid_q <= 1'b0;
                            dump_done_q <= 1'b1;
                        end else begin
                            addr_q     <= addr_d;
                            out_data_q <= mem_q[addr_d];
                            out_addr_q <= addr_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign load_done = load_done_q;
    assign dump_done = dump_done_q;
    assign count     = count_q;
    assign state_dbg = state_q;

endmodule

// File: doc/mem_stream_loader.md
Name: mem_stream_loader

Overview:
- Hardware counterpart to the team's file-to-memory preload path: fills an internal DEPTH x WIDTH memory from a valid/ready input word stream.
- Streams the stored contents back out in address order over a valid/ready output, for checking or forwarding.
- Sits between a word source (host/UART deframer) and downstream consumers of the 8 x 3-bit table.

Parameters:
- WIDTH, 3, bits per memory word
- DEPTH, 8, number of words (power of two, >= 2)
- ADDR_W, 3, address width, equals log2(DEPTH)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a load pass; sampled only in IDLE
- dump  input  1  request a dump pass; sampled only in IDLE
- in_valid  input  1  input word valid
- in_data  input  WIDTH  input word
- in_ready  output  1  loader accepts a word this cycle
- out_valid  output  1  output word valid
- out_data  output  WIDTH  memory word being presented
- out_addr  output  ADDR_W  address of out_data
- out_ready  input  1  downstream accepts out_data
- busy  output  1  state is not IDLE
- load_done  output  1  one-cycle pulse after the last word is written
- dump_done  output  1  one-cycle pulse after the last word is accepted
- count  output  ADDR_W+1  words written in the current or last load pass

Behaviour:
- Clock and reset: single clock domain, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; memory cleared to 0; addr=0; count=0. All outputs are 0.
- Reset mid-load or mid-dump: abandon the pass, return to IDLE, clear memory. No done pulse is generated.

State machine: states IDLE, LOAD, DUMP.
- IDLE with start=1: go to LOAD next cycle; addr<=0, count<=0.
- IDLE with dump=1 and start=0: go to DUMP next cycle; addr<=0.
- start takes priority over dump when both are high.
- start/dump asserted outside IDLE: ignored, no queuing.

LOAD:
- in_ready=1, decoded combinationally from state.
- On in_valid & in_ready: mem[addr]<=in_data, addr<=addr+1, count<=count+1.
- Write on the last address (addr==DEPTH-1): next state IDLE and load_done=1 for exactly one cycle. count ends at DEPTH and addr wraps to 0.
- in_valid=0 stalls indefinitely with no change.

DUMP:
- out_valid, out_data and out_addr are registered.
- Cycle after entry: out_valid=1, out_data=mem[0], out_addr=0.
- Handshake is out_valid & out_ready.
- While out_valid & !out_ready: out_data/out_addr held stable.
- Handshake at cycle t on a non-last word: at t+1 present mem[addr+1], out_valid stays 1. Throughput is one word/cycle with out_ready held high.
- Handshake on addr==DEPTH-1: next cycle out_valid=0, dump_done=1 for one cycle, state IDLE.
- in_ready=0 throughout DUMP.

Other rules:
- out_valid=0 outside DUMP. out_data/out_addr hold their last values when out_valid=0.
- busy=1 exactly when state is LOAD or DUMP.
- count holds its value across IDLE and DUMP until the next start.
- A word written in LOAD is visible to a dump started in any later cycle.

Test Plan:
- Reset, then start; feed 3,5,1,7,0,2,6,4 with in_valid held high -> in_ready high for 8 cycles, load_done pulse on the cycle after the 8th word, count=8, busy falls.
- Then dump with out_ready=1 -> out_data 3,5,1,7,0,2,6,4 on consecutive cycles, out_addr 0..7, dump_done pulses once, out_valid=0 afterwards.
- Dump with out_ready toggling 1,0,0,1,... -> each word held stable while out_ready=0, no word skipped or repeated, same 8-word sequence.
- Load with in_valid gaps (2 idle cycles between words) -> no spurious writes, count increments only on handshakes, final memory matches the input words.
- start and dump high together in IDLE -> LOAD entered. dump pulsed during LOAD -> ignored, no DUMP afterwards.
- rst asserted after the 4th word of a load, then dump -> all 8 words read as 0, count=0, no load_done pulse.
